// File: rtl/dr_pkg.sv
// Shared constants for the data-recovery block: oversampling ratio,
// elastic-buffer depth and the widths derived from them.
package dr_pkg;

    localparam int OSR        = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int PH_W       = $clog2(OSR);

endpackage

// File: rtl/dr_elastic_fifo.sv
// One-bit-wide elastic buffer between the recovered-bit rate and the local
// bit-rate reference. Pointers wrap naturally (power-of-two depth); a push
// into a full buffer and a pop from an empty one are both ignored.
module dr_elastic_fifo
    import dr_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic clock_5x,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fill;
    logic          wr_en;
    logic          rd_en;

    assign full  = (fill == FULL_LVL);
    assign empty = (fill == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr];

    // Pointer and fill-level bookkeeping; simultaneous push and pop cancel.
    always_ff @(posedge clock_5x) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   fill <= fill + (AW + 1)'(1);
                2'b01:   fill <= fill - (AW + 1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock_5x) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dr_toplevel.sv
// Oversampling clock/data recovery: synchronizes the serial input, tracks
// transitions to place a sample point mid-UI, and re-times the recovered
// bits onto the local bit-rate reference through an elastic buffer.
module dr_toplevel
    import dr_pkg::*;
#(
    parameter int OSR        = dr_pkg::OSR,
    parameter int FIFO_DEPTH = dr_pkg::FIFO_DEPTH
) (
    input  logic clock_5x,
    input  logic reset,
    input  logic clock_480,
    input  logic data_in,
    output logic data_out
);

    localparam int PH_W = $clog2(OSR);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [PH_W-1:0] HALF_PH  = PH_W'(OSR / 2);
    localparam logic [PH_W-1:0] LAST_PH  = PH_W'(OSR - 1);
    localparam logic [AW:0]     START_M1 = (AW + 1)'(FIFO_DEPTH / 2 - 1);

    // Majority vote over one UI worth of samples; a tie falls back to the
    // centre sample of the window.
    function automatic logic vote(input logic [OSR-1:0] w);
        int n;
        n = $countones(w);
        if (n > OSR / 2)      return 1'b1;
        else if (n < OSR / 2) return 1'b0;
        else                  return w[OSR/2];
    endfunction

    // Sample point half a UI after the phase at which the edge was seen.
    function automatic logic [PH_W-1:0] mid_ui(input logic [PH_W-1:0] e);
        logic [PH_W:0] s;
        s = {1'b0, e} + (PH_W + 1)'(OSR / 2);
        if (s >= (PH_W + 1)'(OSR)) s = s - (PH_W + 1)'(OSR);
        return s[PH_W-1:0];
    endfunction

    logic            din_p0, din_p1;
    logic [OSR-1:0]  smp_sr;
    logic            ck_p0, ck_p1, ck_p2;
    logic            rd_stb;
    logic [PH_W-1:0] phase_cnt;
    logic [PH_W-1:0] samp_ph;
    logic            edge_flag;
    logic            push_vld;
    logic            push_bit;
    logic            started;
    logic [AW:0]     start_cnt;
    logic            pop;
    logic            fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;

    // Edges are detected in the middle of the sample window, so when the
    // sample point (half a UI later) arrives the whole window holds exactly
    // one UI of the current bit and the vote sees a clean bit.
    assign edge_flag = smp_sr[OSR/2] ^ smp_sr[OSR/2-1];
    assign rd_stb    = ck_p1 & ~ck_p2;
    assign push_vld  = (phase_cnt == samp_ph);
    assign push_bit  = vote(smp_sr);
    assign pop       = rd_stb & started;

    // Input synchronizers and the oversampling shift register.
    always_ff @(posedge clock_5x) begin
        if (reset) begin
            din_p0 <= 1'b0;
            din_p1 <= 1'b0;
            smp_sr <= '0;
            ck_p0  <= 1'b0;
            ck_p1  <= 1'b0;
            ck_p2  <= 1'b0;
        end else begin
            din_p0 <= data_in;
            din_p1 <= din_p0;
            smp_sr <= {smp_sr[OSR-2:0], din_p1};
            ck_p0  <= clock_480;
            ck_p1  <= ck_p0;
            ck_p2  <= ck_p1;
        end
    end

    // Free-running phase counter and edge-driven sample-phase tracking.
    always_ff @(posedge clock_5x) begin
        if (reset) begin
            phase_cnt <= '0;
            samp_ph   <= HALF_PH;
        end else begin
            phase_cnt <= (phase_cnt == LAST_PH) ? '0 : phase_cnt + PH_W'(1);
            if (edge_flag) samp_ph <= mid_ui(phase_cnt);
        end
    end

    // Hold off reading until the buffer is half full for a fixed latency.
    always_ff @(posedge clock_5x) begin
        if (reset) begin
            started   <= 1'b0;
            start_cnt <= '0;
        end else if (!started && push_vld && !fifo_full) begin
            start_cnt <= start_cnt + (AW + 1)'(1);
            if (start_cnt == START_M1) started <= 1'b1;
        end
    end

    // Output register: one bit per reference period, held on underflow.
    always_ff @(posedge clock_5x) begin
        if (reset)                    data_out <= 1'b0;
        else if (pop && !fifo_empty)  data_out <= fifo_dout;
    end

    dr_elastic_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_5x (clock_5x),
        .reset    (reset),
        .push     (push_vld),
        .pop      (pop),
        .din      (push_bit),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_dr_toplevel.sv
// Directed bench for dr_toplevel: streams known bit sequences at nominal,
// offset and jittered sender rates, then aligns the recovered stream to the
// transmitted one and compares every bit.
module tb_dr_toplevel;

    logic clock_5x  = 1'b0;
    logic reset     = 1'b1;
    logic clock_480 = 1'b0;
    logic data_in   = 1'b0;
    logic data_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic tx[$];
    logic rx[$];

    dr_toplevel dut (
        .clock_5x  (clock_5x),
        .reset     (reset),
        .clock_480 (clock_480),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    // 200 ps fast clock, 2000 ps reference offset from its edges.
    always #100 clock_5x = ~clock_5x;

    initial begin
        #50;
        forever #1000 clock_480 = ~clock_480;
    end

    initial begin
        #50000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic make_random(input int n);
        tx.delete();
        tx.push_back(1'b1); tx.push_back(1'b0); tx.push_back(1'b1); tx.push_back(1'b0);
        for (int i = 4; i < n; i++) tx.push_back(logic'($urandom_range(1, 0)));
    endtask

    task automatic make_runs();
        tx.delete();
        tx.push_back(1'b1); tx.push_back(1'b0); tx.push_back(1'b1); tx.push_back(1'b0);
        for (int i = 0; i < 64; i++) tx.push_back(1'b1);
        for (int i = 0; i < 64; i++) tx.push_back(logic'(i % 2));
        for (int i = 0; i < 64; i++) tx.push_back(1'b0);
        for (int i = 0; i < 64; i++) tx.push_back(logic'((i + 1) % 2));
        for (int i = 0; i < 32; i++) tx.push_back(logic'($urandom_range(1, 0)));
    endtask

    task automatic do_reset(input string tag);
        data_in = 1'b0;
        @(negedge clock_5x);
        reset = 1'b1;
        repeat (2) @(posedge clock_5x);
        #1 check({tag, "_rst_dout"}, data_out, 0);
        @(negedge clock_5x);
        reset = 1'b0;
    endtask

    task automatic send(input int period, input bit jit);
        int d;
        for (int i = 0; i < tx.size(); i++) begin
            data_in = tx[i];
            d = period;
            if (jit) d = period + int'($urandom_range(4, 0)) - 2;
            #(d);
        end
    endtask

    task automatic collect(input int n);
        rx.delete();
        repeat (n) begin
            @(negedge clock_480);
            rx.push_back(data_out);
        end
    endtask

    function automatic bit window_ok(input int k, input int j);
        for (int i = 0; i < 24; i++) begin
            if (k + i >= rx.size() || j + i >= tx.size()) return 1'b0;
            if (rx[k + i] !== tx[j + i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic score(input string tag, input int jmin, input int jmax, output int k_out);
        int k_f;
        int j_f;
        int errs;
        int cmp;
        k_f = -1; j_f = 0; errs = 0; cmp = 0;
        for (int kk = 0; kk <= 60 && k_f < 0; kk++)
            for (int jj = jmin; jj <= jmax && k_f < 0; jj++)
                if (window_ok(kk, jj)) begin
                    k_f = kk;
                    j_f = jj;
                end
        check({tag, "_lock"}, k_f >= 0, 1);
        if (k_f >= 0)
            for (int i = j_f; i < tx.size() && (k_f + i - j_f) < rx.size(); i++) begin
                cmp++;
                if (rx[k_f + i - j_f] !== tx[i]) errs++;
            end
        check({tag, "_bits"}, errs, 0);
        check({tag, "_span"}, cmp >= 200, 1);
        k_out = k_f;
    endtask

    task automatic run_stream(input string tag, input int period, input bit jit, output int k);
        do_reset(tag);
        fork
            send(period, jit);
            collect(tx.size() + 60);
        join
        score(tag, 0, 0, k);
    endtask

    initial begin
        int k;
        void'($urandom(32'd7));

        make_random(500);
        run_stream("nom", 2000, 1'b0, k);
        check("nom_prepop_zero", rx[0], 0);
        check("nom_latency", (k >= 2 && k <= 20), 1);

        make_random(500);
        run_stream("slow", 2002, 1'b0, k);

        make_random(500);
        run_stream("fast", 1998, 1'b0, k);

        make_random(500);
        run_stream("jit", 2000, 1'b1, k);

        make_runs();
        run_stream("runs", 2000, 1'b0, k);

        make_random(500);
        do_reset("mid");
        fork
            send(2000, 1'b0);
            begin
                repeat (200) @(negedge clock_480);
                @(negedge clock_5x);
                reset = 1'b1;
                @(posedge clock_5x);
                #1 check("mid_dout_cleared", data_out, 0);
                @(posedge clock_5x);
                @(negedge clock_5x);
                reset = 1'b0;
                collect(330);
            end
        join
        score("mid", 180, 280, k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
